// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer-type encodings, response codes, transfer
// size encodings, and a helper that classifies an address phase as legal or
// erroring for a given data-bus width.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } trans_e;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  localparam logic [2:0] SIZE_BYTE  = 3'd0;
  localparam logic [2:0] SIZE_HALF  = 3'd1;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [2:0] SIZE_DWORD = 3'd3;

  // A transfer is in error when it is wider than the bus or when the address
  // is not aligned to the transfer size. Sizes above 3 are always rejected
  // first, so only three low address bits ever matter for alignment.
  function automatic logic xfer_error(input logic [2:0] size,
                                      input logic [2:0] addr_lo,
                                      input logic [2:0] max_size);
    logic [2:0] mask;
    mask = '0;
    if (size > max_size) begin
      return 1'b1;
    end
    mask = 3'((4'd1 << size) - 4'd1);
    return |(addr_lo & mask);
  endfunction

endpackage

// File: rtl/ahb_byte_lanes.sv
// Byte-lane strobe generator.
// Ports:
//   size    - transfer size, log2 of bytes
//   addr_lo - byte offset of the transfer within the data word
//   strb    - one bit per byte lane, set for every lane the transfer touches
module ahb_byte_lanes
  import ahb_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic [2:0]                       size,
  input  logic [$clog2(DataWidth/8)-1:0]   addr_lo,
  output logic [DataWidth/8-1:0]           strb
);

  localparam int unsigned Lanes    = DataWidth / 8;
  localparam int unsigned ByteIdxW = $clog2(Lanes);

  // A lane is enabled when it falls in the same size-aligned block as the
  // transfer address; shifting both by size discards the in-block offset.
  always_comb begin
    strb = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      if ((ByteIdxW'(i) >> size) == (addr_lo >> size)) begin
        strb[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB subordinate backed by a small register-file SRAM.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   sel         - decoder select for this subordinate
//   addr, trans, write, size - address-phase signals
//   wdata       - data-phase write data
//   readyIn     - bus-level ready qualifying the address phase
//   rdata       - read data (zero except in the read completion cycle)
//   readyOut    - transfer done from this subordinate
//   resp        - OKAY (0) / ERROR (1)
module ahb_sram_subordinate
  import ahb_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned Depth      = 16,
  parameter int unsigned WaitStates = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic [AddrWidth-1:0] addr,
  input  logic [1:0]           trans,
  input  logic                 write,
  input  logic [2:0]           size,
  input  logic [DataWidth-1:0] wdata,
  input  logic                 readyIn,
  output logic [DataWidth-1:0] rdata,
  output logic                 readyOut,
  output logic                 resp
);

  localparam int unsigned Lanes    = DataWidth / 8;
  localparam int unsigned ByteIdxW = $clog2(Lanes);
  localparam int unsigned IdxW     = $clog2(Depth);
  localparam logic [2:0]  MaxSize  = 3'(ByteIdxW);
  localparam logic [2:0]  WaitLoad = 3'((WaitStates == 0) ? 0 : WaitStates - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           wcnt_q, wcnt_d;
  logic                 write_q;
  logic [2:0]           size_q;
  logic [ByteIdxW-1:0]  lo_q;
  logic [IdxW-1:0]      idx_q;
  logic [DataWidth-1:0] mem [Depth];
  logic [Lanes-1:0]     strb;
  logic                 take;
  logic                 err_in;
  trans_e               trans_t;
  logic                 unused_addr;

  assign trans_t     = trans_e'(trans);
  // Address bits above the word index are deliberately ignored (wrap).
  assign unused_addr = ^addr;
  assign err_in      = xfer_error(size, addr[2:0], MaxSize);

  // New address phases are only taken while the previous transfer is in its
  // final (ready-high) cycle or the bus is idle.
  assign take = sel && readyIn
             && (trans_t == TRANS_NONSEQ || trans_t == TRANS_SEQ)
             && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR2);

  ahb_byte_lanes #(
    .DataWidth (DataWidth)
  ) u_lanes (
    .size    (size_q),
    .addr_lo (lo_q),
    .strb    (strb)
  );

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    readyOut = 1'b1;
    resp     = RESP_OKAY;
    rdata    = '0;

    case (state_q)
      S_WAIT: begin
        readyOut = 1'b0;
      end
      S_DONE: begin
        if (!write_q) begin
          rdata = mem[idx_q];
        end
      end
      S_ERR1: begin
        readyOut = 1'b0;
        resp     = RESP_ERROR;
      end
      S_ERR2: begin
        resp = RESP_ERROR;
      end
      default: ;
    endcase

    if (take) begin
      wcnt_d = WaitLoad;
      if (err_in) begin
        state_d = S_ERR1;
      end else if (WaitStates > 0) begin
        state_d = S_WAIT;
      end else begin
        state_d = S_DONE;
      end
    end else begin
      case (state_q)
        S_WAIT: begin
          if (wcnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            wcnt_d = wcnt_q - 3'd1;
          end
        end
        S_ERR1:  state_d = S_ERR2;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      lo_q    <= '0;
      idx_q   <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (take) begin
        write_q <= write;
        size_q  <= size;
        lo_q    <= addr[ByteIdxW-1:0];
        idx_q   <= addr[ByteIdxW +: IdxW];
      end
      // Errored transfers never reach DONE, so storage is untouched for them.
      if (state_q == S_DONE && write_q) begin
        for (int unsigned b = 0; b < Lanes; b++) begin
          if (strb[b]) begin
            mem[idx_q][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
module tb_ahb_sram_subordinate;
  import ahb_pkg::*;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: WaitStates=0, DUT b: WaitStates=2
  logic        a_rst, a_sel, a_write, a_hold, a_rin, a_ready, a_resp;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [1:0]  a_trans;
  logic [2:0]  a_size;
  logic        b_rst, b_sel, b_write, b_hold, b_rin, b_ready, b_resp;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_trans;
  logic [2:0]  b_size;

  assign a_rin = a_ready & ~a_hold;
  assign b_rin = b_ready & ~b_hold;

  ahb_sram_subordinate #(.DataWidth(32), .AddrWidth(32), .Depth(16), .WaitStates(0)) dut_a (
    .clk(clk), .reset(a_rst), .sel(a_sel), .addr(a_addr), .trans(a_trans),
    .write(a_write), .size(a_size), .wdata(a_wdata), .readyIn(a_rin),
    .rdata(a_rdata), .readyOut(a_ready), .resp(a_resp)
  );

  ahb_sram_subordinate #(.DataWidth(32), .AddrWidth(32), .Depth(16), .WaitStates(2)) dut_b (
    .clk(clk), .reset(b_rst), .sel(b_sel), .addr(b_addr), .trans(b_trans),
    .write(b_write), .size(b_size), .wdata(b_wdata), .readyIn(b_rin),
    .rdata(b_rdata), .readyOut(b_ready), .resp(b_resp)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] model [2][16];

  typedef struct {
    int          d;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct packed {
    logic       ready;
    logic       resp;
    logic       done;
    logic       wr;
    logic [3:0] idx;
    logic [3:0] mask;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 0) ? a_ready : b_ready;
  endfunction
  function automatic logic get_resp(input int d);
    return (d == 0) ? a_resp : b_resp;
  endfunction
  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? a_rdata : b_rdata;
  endfunction

  task automatic chk_out(input string name, input int d, input logic rdy,
                         input logic rsp, input logic [31:0] rd);
    chk({name, ".ready"}, 32'(get_ready(d)), 32'(rdy));
    chk({name, ".resp"},  32'(get_resp(d)),  32'(rsp));
    chk({name, ".rdata"}, get_rdata(d), rd);
  endtask

  task automatic drive_addr(input int d, input logic s, input logic [1:0] tr,
                            input logic w, input logic [2:0] sz, input logic [31:0] ad);
    if (d == 0) begin
      a_sel = s; a_trans = tr; a_write = w; a_size = sz; a_addr = ad;
    end else begin
      b_sel = s; b_trans = tr; b_write = w; b_size = sz; b_addr = ad;
    end
  endtask

  task automatic drive_wdata(input int d, input logic [31:0] v);
    if (d == 0) a_wdata = v;
    else        b_wdata = v;
  endtask

  // Single non-pipelined transfer; called at a negedge with the DUT idle.
  task automatic op(input string name, input int d, input logic wr, input logic [2:0] sz,
                    input logic [31:0] ad, input logic [31:0] wd, input logic err,
                    input logic [31:0] rd);
    int ws;
    ws = (d == 0) ? 0 : 2;
    drive_addr(d, 1'b1, TRANS_NONSEQ, wr, sz, ad);
    @(negedge clk);
    drive_addr(d, 1'b0, TRANS_IDLE, 1'b0, 3'd0, 32'h0);
    drive_wdata(d, wd);
    if (err) begin
      chk_out({name, ".err1"}, d, 1'b0, 1'b1, 32'h0);
      @(negedge clk);
      chk_out({name, ".err2"}, d, 1'b1, 1'b1, 32'h0);
      @(negedge clk);
    end else begin
      for (int k = 0; k < ws; k++) begin
        chk_out($sformatf("%s.wait%0d", name, k), d, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
      end
      chk_out({name, ".done"}, d, 1'b1, 1'b0, rd);
      @(negedge clk);
    end
  endtask

  // Randomised pipelined traffic checked against a transaction-level model:
  // each accepted transfer expands into its expected per-cycle responses.
  task automatic rand_run(input int d, input int ncyc);
    exp_t        eq[$];
    exp_t        cur;
    exp_t        e;
    int          c;
    int          ws;
    int          ad;
    int          sz;
    int          r;
    int          nbytes;
    logic        s, w;
    logic [1:0]  tr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    ws = (d == 0) ? 0 : 2;
    c = 0;
    while (c < ncyc || eq.size() != 0) begin
      if (eq.size() != 0) begin
        cur = eq.pop_front();
      end else begin
        cur = '0;
        cur.ready = 1'b1;
      end
      exp_rd = (cur.done && !cur.wr) ? model[d][cur.idx] : 32'h0;
      chk_out($sformatf("rand%0d.c%0d", d, c), d, cur.ready, cur.resp, exp_rd);

      wd = $urandom;
      drive_wdata(d, wd);
      if (cur.done && cur.wr) begin
        for (int b = 0; b < 4; b++) begin
          if (cur.mask[b]) model[d][cur.idx][8*b +: 8] = wd[8*b +: 8];
        end
      end

      if (cur.ready) begin
        if (c < ncyc) begin
          s  = ($urandom_range(0, 7) != 0);
          tr = 2'($urandom_range(0, 3));
          w  = 1'($urandom_range(0, 1));
          r  = $urandom_range(0, 9);
          sz = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : $urandom_range(3, 7);
          ad = $urandom_range(0, 127);
          if ($urandom_range(0, 3) != 0) ad = ad - (ad % (1 << sz));
          drive_addr(d, s, tr, w, 3'(sz), 32'(ad));
          if (s && (tr == 2'd2 || tr == 2'd3)) begin
            if (sz > 2 || (ad % (1 << sz)) != 0) begin
              e = '0; e.resp = 1'b1;
              eq.push_back(e);
              e.ready = 1'b1;
              eq.push_back(e);
            end else begin
              e = '0;
              for (int k = 0; k < ws; k++) eq.push_back(e);
              nbytes  = 1 << sz;
              e.ready = 1'b1;
              e.done  = 1'b1;
              e.wr    = w;
              e.idx   = 4'((ad / 4) % 16);
              e.mask  = 4'(((1 << nbytes) - 1) << (ad % 4));
              eq.push_back(e);
            end
          end
        end else begin
          drive_addr(d, 1'b0, TRANS_IDLE, 1'b0, 3'd0, 32'h0);
        end
      end
      c++;
      @(negedge clk);
    end
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{0, 1'b1, 3'd2, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{0, 1'b0, 3'd2, 32'h08, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{0, 1'b1, 3'd2, 32'h04, 32'h11223344, 1'b0, 32'h0};
    tbl[3]  = '{0, 1'b1, 3'd0, 32'h05, 32'h0000AB00, 1'b0, 32'h0};
    tbl[4]  = '{0, 1'b0, 3'd2, 32'h04, 32'h0,        1'b0, 32'h1122AB44};
    tbl[5]  = '{0, 1'b1, 3'd1, 32'h03, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[6]  = '{0, 1'b0, 3'd2, 32'h00, 32'h0,        1'b0, 32'h0};
    tbl[7]  = '{0, 1'b0, 3'd2, 32'h04, 32'h0,        1'b0, 32'h1122AB44};
    tbl[8]  = '{0, 1'b1, 3'd2, 32'h40, 32'h0BADF00D, 1'b0, 32'h0};
    tbl[9]  = '{0, 1'b0, 3'd2, 32'h00, 32'h0,        1'b0, 32'h0BADF00D};
    tbl[10] = '{0, 1'b1, 3'd1, 32'h06, 32'h55660000, 1'b0, 32'h0};
    tbl[11] = '{0, 1'b0, 3'd2, 32'h04, 32'h0,        1'b0, 32'h5566AB44};
    tbl[12] = '{0, 1'b0, 3'd3, 32'h00, 32'h0,        1'b1, 32'h0};
    tbl[13] = '{1, 1'b1, 3'd2, 32'h0C, 32'hCAFEF00D, 1'b0, 32'h0};
    tbl[14] = '{1, 1'b0, 3'd2, 32'h0C, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[15] = '{1, 1'b0, 3'd1, 32'h0E, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[16] = '{1, 1'b1, 3'd1, 32'h01, 32'h12345678, 1'b1, 32'h0};

    a_hold = 1'b0; b_hold = 1'b0;
    a_wdata = '0;  b_wdata = '0;
    drive_addr(0, 1'b0, TRANS_IDLE, 1'b0, 3'd0, 32'h0);
    drive_addr(1, 1'b0, TRANS_IDLE, 1'b0, 3'd0, 32'h0);
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_out("reset_a", 0, 1'b1, 1'b0, 32'h0);
    chk_out("reset_b", 1, 1'b1, 1'b0, 32'h0);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);

    // Pipelined write then read of the same word, WaitStates=0.
    drive_addr(0, 1'b1, TRANS_NONSEQ, 1'b1, 3'd2, 32'h8);
    @(negedge clk);
    chk_out("b2b_wr_done", 0, 1'b1, 1'b0, 32'h0);
    drive_wdata(0, 32'hDEADBEEF);
    drive_addr(0, 1'b1, TRANS_NONSEQ, 1'b0, 3'd2, 32'h8);
    @(negedge clk);
    chk_out("b2b_rd_done", 0, 1'b1, 1'b0, 32'hDEADBEEF);
    drive_addr(0, 1'b0, TRANS_IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    chk_out("b2b_idle", 0, 1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 17; i++) begin
      op($sformatf("vec%0d", i), tbl[i].d, tbl[i].wr, tbl[i].size, tbl[i].addr,
         tbl[i].wdata, tbl[i].err, tbl[i].rdata);
    end

    // Address phase presented while readyIn is low must be ignored.
    drive_addr(0, 1'b1, TRANS_NONSEQ, 1'b0, 3'd3, 32'h0);
    a_hold = 1'b1;
    @(negedge clk);
    chk_out("hold_ignored", 0, 1'b1, 1'b0, 32'h0);
    a_hold = 1'b0;
    drive_addr(0, 1'b0, TRANS_IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge clk);

    // Reset in the middle of a wait-stated read.
    drive_addr(1, 1'b1, TRANS_NONSEQ, 1'b0, 3'd2, 32'hC);
    @(negedge clk);
    drive_addr(1, 1'b0, TRANS_IDLE, 1'b0, 3'd0, 32'h0);
    chk_out("rst_in_wait", 1, 1'b0, 1'b0, 32'h0);
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    chk_out("rst_after", 1, 1'b1, 1'b0, 32'h0);
    op("rst_rd_c", 1, 1'b0, 3'd2, 32'hC, 32'h0, 1'b0, 32'h0);
    op("rst_rd_0", 1, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 32'h0);

    a_rst = 1'b1; b_rst = 1'b1;
    repeat (2) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    foreach (model[i, j]) model[i][j] = 32'h0;
    rand_run(0, 400);
    rand_run(1, 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
